// File: rtl/hh_spike_encoder_if.sv
// -----------------------------------------------------------------------------
// hh_spike_encoder_if
//   Valid/ready event port carrying one {isi, peak} record per detected spike.
//
//   evt_valid  producer -> consumer  head event present
//   evt_ready  consumer -> producer  consumer takes the head event this cycle
//   evt_isi    producer -> consumer  onset-to-onset interval in samples
//   evt_peak   producer -> consumer  signed peak membrane potential
//
//   master : event producer (the encoder)
//   slave  : event consumer (readout logic)
// -----------------------------------------------------------------------------
interface hh_spike_encoder_if #(
   parameter int ISI_W = 16
);
   logic                    evt_valid;
   logic                    evt_ready;
   logic        [ISI_W-1:0] evt_isi;
   logic signed [15:0]      evt_peak;

   modport master (
      output evt_valid,
      output evt_isi,
      output evt_peak,
      input  evt_ready
   );

   modport slave (
      input  evt_valid,
      input  evt_isi,
      input  evt_peak,
      output evt_ready
   );
endinterface

// File: rtl/hh_spike_encoder.sv
// -----------------------------------------------------------------------------
// hh_spike_encoder
//   Turns the neuron core's membrane-potential sample stream into spike events.
//   An onset is a sample >= THRESH seen while armed; the spike ends at the
//   first sample below THRESH - HYST. Each spike yields one {isi, peak} event
//   queued in a 2-entry buffer; a refractory window of REFRACT samples follows
//   every offset before onsets are looked for again.
//
//   Ports
//     clock        system clock, rising edge
//     reset        asynchronous, active-high reset
//     v_in         signed 16-bit membrane-potential sample
//     v_valid      v_in is valid this cycle (always accepted)
//     spike        one-cycle pulse the cycle after an onset sample
//     evt          event port (master side of hh_spike_encoder_if)
//     overflow     sticky: an event was dropped because the buffer was full
//     spike_count  saturating onset count, or 0 when the counter is disabled
//
//   Build option
//     HH_SPIKE_COUNT_EN  when defined, a 16-bit saturating onset counter drives
//                        spike_count; otherwise spike_count is tied to zero.
// -----------------------------------------------------------------------------
module hh_spike_encoder #(
   parameter logic signed [15:0] THRESH  = 16'sd0,
   parameter logic        [15:0] HYST    = 16'd5,
   parameter int                 REFRACT = 8,
   parameter int                 ISI_W   = 16
) (
   input  logic                clock,
   input  logic                reset,
   input  logic signed [15:0]  v_in,
   input  logic                v_valid,
   output logic                spike,
   hh_spike_encoder_if.master  evt,
   output logic                overflow,
   output logic [15:0]         spike_count
);

   localparam int RC_W = (REFRACT > 1) ? $clog2(REFRACT + 1) : 1;

   // Offset threshold widened to 17 bits so a low THRESH minus HYST cannot wrap.
   localparam logic signed [16:0] OFF_THRESH =
      $signed({THRESH[15], THRESH}) - $signed({1'b0, HYST});

   typedef enum logic [1:0] {
      ARMED,
      ABOVE,
      REFR
   } state_t;

   typedef struct packed {
      logic        [ISI_W-1:0] isi;
      logic signed [15:0]      peak;
   } evt_t;

   state_t             state;
   logic [ISI_W-1:0]   isi_cnt;
   logic [ISI_W-1:0]   isi_lat;
   logic               first;
   logic signed [15:0] peak;
   logic [RC_W-1:0]    rcnt;

   // Two buffer slots; the head slot is the registered output itself.
   evt_t               head_q, tail_q;
   logic               head_v, tail_v;

   logic signed [16:0] v_ext;
   logic               onset, offset;
   logic [ISI_W-1:0]   isi_inc;
   logic               pop;
   evt_t               new_evt;
   evt_t               head_d, tail_d;
   logic               head_vd, tail_vd;
   logic               drop;

   assign v_ext   = {v_in[15], v_in};
   assign onset   = v_valid && (state == ARMED) && (v_in >= THRESH);
   assign offset  = v_valid && (state == ABOVE) && (v_ext < OFF_THRESH);
   assign isi_inc = (isi_cnt == '1) ? isi_cnt : isi_cnt + ISI_W'(1);
   assign pop     = head_v && evt.evt_ready;

   // Peak is taken from the register, so the sub-threshold offset sample
   // never contributes to it.
   assign new_evt = '{isi: isi_lat, peak: peak};

   // NOTE: every output of this block is given a default first so no path
   // leaves a variable unassigned, which would otherwise infer a latch.
   always_comb begin
      head_d  = head_q;
      head_vd = head_v;
      tail_d  = tail_q;
      tail_vd = tail_v;
      drop    = 1'b0;
      // Pop first so a push into a full buffer on a pop cycle is not dropped.
      if (pop) begin
         head_d  = tail_q;
         head_vd = tail_v;
         tail_vd = 1'b0;
      end
      if (offset) begin
         if (!head_vd) begin
            head_d  = new_evt;
            head_vd = 1'b1;
         end else if (!tail_vd) begin
            tail_d  = new_evt;
            tail_vd = 1'b1;
         end else begin
            drop = 1'b1;
         end
      end
   end

   // NOTE: sequential state is written with non-blocking assignments so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         // NOTE: the buffer slots are reset too; they are only two entries and
         // a flush on reset must leave clean, deterministic outputs.
         state    <= ARMED;
         isi_cnt  <= '0;
         isi_lat  <= '0;
         first    <= 1'b1;
         peak     <= '0;
         rcnt     <= '0;
         spike    <= 1'b0;
         head_q   <= '0;
         tail_q   <= '0;
         head_v   <= 1'b0;
         tail_v   <= 1'b0;
         overflow <= 1'b0;
      end else begin
         spike    <= onset;
         head_q   <= head_d;
         head_v   <= head_vd;
         tail_q   <= tail_d;
         tail_v   <= tail_vd;
         overflow <= overflow | drop;

         if (v_valid) begin
            if (onset) begin
               isi_lat <= first ? '0 : isi_inc;
               isi_cnt <= '0;
               first   <= 1'b0;
            end else begin
               isi_cnt <= isi_inc;
            end

            unique case (state)
               ARMED: begin
                  if (onset) begin
                     state <= ABOVE;
                     peak  <= v_in;
                  end
               end
               ABOVE: begin
                  if (offset) begin
                     if (REFRACT == 0) begin
                        state <= ARMED;
                     end else begin
                        state <= REFR;
                        rcnt  <= RC_W'(REFRACT);
                     end
                  end else if (v_in > peak) begin
                     peak <= v_in;
                  end
               end
               REFR: begin
                  // The sample seen with rcnt == 1 re-arms but is not itself
                  // evaluated for onset, so exactly REFRACT samples are ignored.
                  if (rcnt <= RC_W'(1)) begin
                     state <= ARMED;
                  end else begin
                     rcnt <= rcnt - RC_W'(1);
                  end
               end
               default: state <= ARMED;
            endcase
         end
      end
   end

   assign evt.evt_valid = head_v;
   assign evt.evt_isi   = head_q.isi;
   assign evt.evt_peak  = head_q.peak;

`ifdef HH_SPIKE_COUNT_EN
   logic [15:0] count_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else if (onset && (count_q != '1)) begin
         count_q <= count_q + 16'd1;
      end
   end

   assign spike_count = count_q;
`else
   assign spike_count = 16'd0;
`endif

endmodule

// File: tb/tb_hh_spike_encoder.sv
// -----------------------------------------------------------------------------
// tb_hh_spike_encoder
//   Directed bench for hh_spike_encoder. A sample-index based model predicts
//   spike, the event queue, overflow and spike_count; a negedge process compares
//   the DUT against it every cycle, and literal expectations pin key results.
// -----------------------------------------------------------------------------
module tb_hh_spike_encoder;

   localparam int THRESH  = 0;
   localparam int HYST    = 5;
   localparam int REFRACT = 8;
   localparam int ISI_MAX = 65535;

   logic               clock = 1'b0;
   logic               reset;
   logic signed [15:0] v_in;
   logic               v_valid;
   logic               spike;
   logic               overflow;
   logic [15:0]        spike_count;

   hh_spike_encoder_if #(.ISI_W(16)) evt_if ();

   hh_spike_encoder #(
      .THRESH  (16'sd0),
      .HYST    (16'd5),
      .REFRACT (REFRACT),
      .ISI_W   (16)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .v_in        (v_in),
      .v_valid     (v_valid),
      .spike       (spike),
      .evt         (evt_if),
      .overflow    (overflow),
      .spike_count (spike_count)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      int isi;
      int peak;
   } ev_t;

   ev_t m_q[$];
   int  m_n     = 0;    // accepted samples since reset
   int  m_last  = -1;   // sample index of the previous onset, -1 if none
   bit  m_above = 1'b0;
   int  m_refr  = 0;    // refractory samples still to be ignored
   int  m_peak  = 0;
   int  m_isi   = 0;
   bit  m_spike = 1'b0;
   bit  m_ovf   = 1'b0;
   int  m_cnt   = 0;

   task automatic model_reset();
      m_q.delete();
      m_n     = 0;
      m_last  = -1;
      m_above = 1'b0;
      m_refr  = 0;
      m_peak  = 0;
      m_isi   = 0;
      m_spike = 1'b0;
      m_ovf   = 1'b0;
      m_cnt   = 0;
   endtask

   task automatic model_edge();
      bit  push;
      bit  pop;
      int  v;
      ev_t ev;
      push    = 1'b0;
      pop     = (m_q.size() > 0) && evt_if.evt_ready;
      m_spike = 1'b0;
      if (v_valid) begin
         v = int'(v_in);
         if (m_above) begin
            if (v < THRESH - HYST) begin
               ev.isi  = m_isi;
               ev.peak = m_peak;
               push    = 1'b1;
               m_above = 1'b0;
               m_refr  = REFRACT;
            end else if (v > m_peak) begin
               m_peak = v;
            end
         end else if (m_refr > 0) begin
            m_refr--;
         end else if (v >= THRESH) begin
            if (m_last < 0) m_isi = 0;
            else            m_isi = (m_n - m_last > ISI_MAX) ? ISI_MAX : m_n - m_last;
            m_last  = m_n;
            m_above = 1'b1;
            m_peak  = v;
            m_spike = 1'b1;
            if (m_cnt < 65535) m_cnt++;
         end
         m_n++;
      end
      if (pop) void'(m_q.pop_front());
      if (push) begin
         if (m_q.size() < 2) m_q.push_back(ev);
         else                m_ovf = 1'b1;
      end
   endtask

   always @(posedge clock or posedge reset) begin
      if (reset) model_reset();
      else       model_edge();
   end

   function automatic int exp_count(input int n);
`ifdef HH_SPIKE_COUNT_EN
      return n;
`else
      return 0;
`endif
   endfunction

   // ---------------- per-cycle comparison ----------------
   always @(negedge clock) begin
      if (cmp_en) begin
         check("spike", int'(spike), int'(m_spike));
         check("evt_valid", int'(evt_if.evt_valid), int'(m_q.size() > 0));
         if (m_q.size() > 0) begin
            check("evt_isi", int'(evt_if.evt_isi), m_q[0].isi);
            check("evt_peak", int'(evt_if.evt_peak), m_q[0].peak);
         end
         check("overflow", int'(overflow), int'(m_ovf));
         check("spike_count", int'(spike_count), exp_count(m_cnt));
      end
   end

   // ---------------- stimulus ----------------
   task automatic send(input int v);
      v_in    = 16'(v);
      v_valid = 1'b1;
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      v_valid = 1'b0;
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic rest(input int n);
      repeat (n) send(-65);
   endtask

   task automatic pulse_reset();
      v_valid = 1'b0;
      reset   = 1'b1;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
   endtask

   initial begin
      reset            = 1'b1;
      v_in             = '0;
      v_valid          = 1'b0;
      evt_if.evt_ready = 1'b1;
      @(posedge clock);
      cmp_en = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;

      // Reset values
      check("rst_evt_valid", int'(evt_if.evt_valid), 0);
      check("rst_overflow", int'(overflow), 0);
      check("rst_spike_count", int'(spike_count), 0);

      // Resting potential: nothing happens
      rest(10);
      check("rest_spike", int'(spike), 0);
      check("rest_evt_valid", int'(evt_if.evt_valid), 0);

      // First spike: -65, 10, 30, 20, -10
      send(-65);
      send(10);
      check("t2_spike_after_onset", int'(spike), 1);
      send(30);
      check("t2_spike_single", int'(spike), 0);
      send(20);
      send(-10);
      check("t2_evt_valid", int'(evt_if.evt_valid), 1);
      check("t2_evt_isi", int'(evt_if.evt_isi), 0);
      check("t2_evt_peak", int'(evt_if.evt_peak), 30);
      rest(REFRACT);

      // Two spikes with onsets 20 samples apart
      send(10); send(30); send(-10);
      rest(REFRACT + 9);
      send(10); send(30); send(-10);
      check("t3_evt_isi", int'(evt_if.evt_isi), 20);
      check("t3_evt_peak", int'(evt_if.evt_peak), 30);
      rest(REFRACT);

      // Above-threshold sample inside the refractory window is ignored
      send(10); send(-10);
      send(-65); send(-65); send(40);
      check("t4_refr_no_spike", int'(spike), 0);
      rest(REFRACT - 3);
      idle(2);
      check("t4_refr_no_event", int'(evt_if.evt_valid), 0);

      // Three spikes with the consumer stalled: third event dropped
      pulse_reset();
      evt_if.evt_ready = 1'b0;
      repeat (3) begin
         send(10); send(-10);
         rest(REFRACT);
      end
      check("t5_overflow", int'(overflow), 1);
      check("t5_evt_valid", int'(evt_if.evt_valid), 1);
      check("t5_head_isi", int'(evt_if.evt_isi), 0);
      check("t5_head_peak", int'(evt_if.evt_peak), 10);
      check("t5_spike_count", int'(spike_count), exp_count(3));

      // Drain one, leaving one buffered, then reset mid-spike
      evt_if.evt_ready = 1'b1;
      idle(1);
      evt_if.evt_ready = 1'b0;
      check("t6_one_left", int'(evt_if.evt_valid), 1);
      check("t6_second_isi", int'(evt_if.evt_isi), 2 + REFRACT);
      send(10);
      check("t6_spike_before_reset", int'(spike), 1);
      reset = 1'b1;
      #1;
      check("t6_rst_evt_valid", int'(evt_if.evt_valid), 0);
      check("t6_rst_overflow", int'(overflow), 0);
      check("t6_rst_spike", int'(spike), 0);
      @(posedge clock);
      #1 reset = 1'b0;
      evt_if.evt_ready = 1'b1;
      rest(2);
      send(10); send(30); send(-10);
      check("t6_post_rst_isi", int'(evt_if.evt_isi), 0);
      check("t6_post_rst_peak", int'(evt_if.evt_peak), 30);
      idle(3);

      cmp_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hh_spike_encoder.md
Name: hh_spike_encoder

Overview:
- Consumes the membrane-potential sample stream produced by the neuron core (signed 16-bit V, one sample per valid strobe).
- Detects action potentials by threshold crossing with hysteresis, tracks each spike's peak, and measures the onset-to-onset inter-spike interval (ISI) in samples.
- Enforces a refractory window and emits one event {isi, peak} per spike through a 2-entry buffered valid/ready port for the readout logic.

Parameters:
- THRESH, 16'sd0: signed onset threshold, same units as V (mV).
- HYST, 16'd5: unsigned hysteresis; offset threshold is THRESH - HYST.
- REFRACT, 8: samples ignored after offset before re-arming; 0 re-arms immediately.
- ISI_W, 16: ISI counter width; counter saturates at all-ones.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- v_in  in  16  signed membrane-potential sample.
- v_valid  in  1  v_in is valid this cycle. Always accepted; there is no backpressure on this side.
- spike  out  1  one-cycle pulse, asserted the cycle after the onset sample.
- evt_valid  out  1  event buffer is non-empty.
- evt_ready  in  1  consumer accepts the head event.
- evt_isi  out  ISI_W  ISI of the head event.
- evt_peak  out  16  signed peak V of the head event.
- overflow  out  1  sticky flag: an event was dropped. Cleared only by reset.
- spike_count  out  16  total onsets (see Optional Feature).

Behaviour:
- Reset values: state ARMED; spike, evt_valid, overflow = 0; evt_isi, evt_peak, spike_count = 0; buffer empty; isi_cnt = 0; first = 1.
- All state advances only on cycles where v_valid = 1. Comparisons are signed. THRESH - HYST is computed at 17 bits so it cannot wrap.
- ISI counter:
  - Increments, saturating, on every accepted sample that is not an onset.
  - On an onset, the captured ISI is isi_cnt + 1 (saturated), or 0 if first = 1.
  - On an onset, isi_cnt is cleared to 0 and first is cleared to 0.
- ARMED:
  - If v_in >= THRESH: go to ABOVE, set peak <= v_in, latch the ISI, pulse spike next cycle, increment spike_count (saturating).
- ABOVE:
  - peak <= max(peak, v_in).
  - If v_in < THRESH - HYST: push {isi, peak} into the buffer. The pushed peak excludes the current, sub-threshold sample.
  - Then go to REFRACT with rcnt = REFRACT, or go straight to ARMED if REFRACT = 0.
- REFRACT:
  - Decrement rcnt per sample; when rcnt reaches 1, go to ARMED.
  - Samples in this state never trigger an onset, even if above THRESH.
  - The re-arm sample is not itself evaluated for onset.
- Event buffer (2-entry FIFO):
  - evt_* fields are registered from the head entry.
  - Pop when evt_valid && evt_ready.
  - Push and pop in the same cycle while full: both occur, no drop.
  - Push while full with no pop: the new event is dropped and overflow is set.
  - Push into an empty buffer: evt_valid rises the next cycle.
- Mid-operation reset: immediate return to reset values. Any in-flight spike is discarded and the buffer is flushed.
- Latency:
  - spike: 1 cycle after the onset sample.
  - event: evt_valid 1 cycle after the offset sample, given an empty buffer.

Optional Feature:
- Macro: HH_SPIKE_COUNT_EN.
- Defined: spike_count is a 16-bit saturating onset counter, reset to 0.
- Undefined: no counter is synthesised and spike_count is tied to 16'd0. All other behaviour is identical.

Test Plan:
- Reset, then 10 samples of -65 → spike stays 0, evt_valid stays 0, state remains ARMED.
- Samples -65, 10, 30, 20, -10 (THRESH=0, HYST=5) → spike pulses once after the 10 sample; one event with isi=0 (first spike), peak=30.
- Two spikes with onsets 20 samples apart and REFRACT=8 → second event reports isi=20.
- Above-threshold sample during REFRACT (e.g. 40 at the 3rd refractory sample) → no spike, no event.
- evt_ready=0 with 3 complete spikes → only the first two are buffered; overflow=1; spike_count=3 (macro on) or 0 (macro off).
- Assert reset while in ABOVE with 1 event buffered → evt_valid=0, overflow=0, spike=0 immediately; the next spike reports isi=0.
